// File: rtl/mips_lsu.sv
// rtl/mips_lsu.sv - load/store initiator between the CPU pipeline and word-wide data memory
module mips_lsu #(
  parameter int RD_LATENCY = 1,
  parameter int BIG_ENDIAN = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RWAIT, MERGE, WR, RESP} stateT;

  // RWAIT covers the read latency beyond the RD cycle itself; count down to zero
  localparam logic [2:0] WAIT_INIT = (RD_LATENCY > 1) ? 3'(RD_LATENCY - 2) : 3'd0;

  stateT       state;
  logic [2:0]  waitCnt;
  logic [1:0]  laneReg;
  logic [1:0]  sizeReg;
  logic        wrReg;
  logic        signedReg;
  logic [15:0] wdataReg;
  logic        badReq;

  // Bit offset of the addressed byte/halfword inside the memory word
  function automatic logic [4:0] laneShift(input logic [1:0] size, input logic [1:0] lane);
    logic [4:0] sh;
    sh = 5'd0;
    if (size == 2'b00)
      sh = {(BIG_ENDIAN != 0) ? ~lane : lane, 3'b000};
    else if (size == 2'b01)
      sh = {(BIG_ENDIAN != 0) ? ~lane[1] : lane[1], 4'b0000};
    return sh;
  endfunction

  // Pull the addressed lane out of a word and sign/zero extend it
  function automatic logic [31:0] extractLoad(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic sgn);
    logic [31:0] shifted;
    logic [31:0] res;
    shifted = word >> laneShift(size, lane);
    case (size)
      2'b00:   res = {{24{sgn & shifted[7]}}, shifted[7:0]};
      2'b01:   res = {{16{sgn & shifted[15]}}, shifted[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace only the addressed lane(s) of the old word with the new store data
  function automatic logic [31:0] mergeLane(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] lane, input logic [15:0] wdata);
    logic [31:0] mask;
    logic [31:0] ins;
    logic [4:0]  sh;
    sh   = laneShift(size, lane);
    mask = (size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    ins  = {16'b0, wdata} & mask;
    return (word & ~(mask << sh)) | (ins << sh);
  endfunction

  assign req_ready = (state == IDLE) & ~rst;

  // Reserved size or misaligned halfword/word is rejected without touching memory
  always_comb begin
    badReq = 1'b0;
    case (req_size)
      2'b01:   badReq = req_addr[0];
      2'b10:   badReq = (req_addr[1:0] != 2'b00);
      2'b11:   badReq = 1'b1;
      default: badReq = 1'b0;
    endcase
  end

  // Access sequencer: all outputs are registered and driven from the state transitions
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      waitCnt   <= 3'd0;
      laneReg   <= 2'b00;
      sizeReg   <= 2'b00;
      wrReg     <= 1'b0;
      signedReg <= 1'b0;
      wdataReg  <= 16'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            laneReg   <= req_addr[1:0];
            sizeReg   <= req_size;
            wrReg     <= req_wr;
            signedReg <= req_signed;
            wdataReg  <= req_wdata[15:0];
            if (badReq) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= RESP;
            end else begin
              mem_addr <= {req_addr[31:2], 2'b00};
              if (req_wr && (req_size == 2'b10)) begin
                mem_wdata <= req_wdata;
                mem_wr    <= 1'b1;
                state     <= WR;
              end else begin
                // loads and sub-word stores both start with a read of the word
                mem_rd <= 1'b1;
                state  <= RD;
              end
            end
          end
        end
        RD: begin
          mem_rd <= 1'b0;
          if (RD_LATENCY == 1) begin
            state <= MERGE;
          end else begin
            waitCnt <= WAIT_INIT;
            state   <= RWAIT;
          end
        end
        RWAIT: begin
          if (waitCnt == 3'd0)
            state <= MERGE;
          else
            waitCnt <= waitCnt - 3'd1;
        end
        MERGE: begin
          // mem_rdata is valid in this cycle and is consumed directly
          if (wrReg) begin
            mem_wdata <= mergeLane(mem_rdata, sizeReg, laneReg, wdataReg);
            mem_wr    <= 1'b1;
            state     <= WR;
          end else begin
            rsp_valid <= 1'b1;
            rsp_rdata <= extractLoad(mem_rdata, sizeReg, laneReg, signedReg);
            state     <= RESP;
          end
        end
        WR: begin
          mem_wr    <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
